// File: rtl/run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : run_monitor
// Description : Watches a processor's program counter during a program run.
//               A start pulse arms a run. It computes the exit address, which
//               is the last instruction plus the pipeline drain, and it latches
//               the cycle limit. The run then ends in DONE when pc reaches the
//               exit address, or in TLE when the cycle limit is reached.
//               Build option:
//                 RUN_MONITOR_STALL_CNT_EN - when defined, stall_cycles counts
//                 RUN cycles in which pc did not change. When undefined,
//                 stall_cycles is tied to 0.
// Ports       : clk, rstn (synchronous, active-low)
//               start, abort              - run control
//               num_instr, timeout        - sampled on start
//               pc                        - observed program counter
//               busy, done, timed_out     - registered state decodes
//               cycles, exit_addr         - run progress / latched exit
//               stall_cycles              - optional stall counter
// Revision    : 1.0 - initial release
// ============================================================================
module run_monitor #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  CNT_WIDTH  = 16,
    parameter int                  STAGES     = 5,
    parameter logic [PC_WIDTH-1:0] TEXT_START = PC_WIDTH'('h00400000)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] num_instr,
    input  logic [CNT_WIDTH-1:0] timeout,
    input  logic [PC_WIDTH-1:0]  pc,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out,
    output logic [CNT_WIDTH-1:0] cycles,
    output logic [PC_WIDTH-1:0]  exit_addr,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;
    localparam logic [1:0] c_st_tle  = 2'd3;

    // The last instruction retires STAGES-1 fetches after its own fetch.
    localparam logic [PC_WIDTH-1:0]  c_drain_offset = PC_WIDTH'(4 * (STAGES - 1));
    localparam logic [CNT_WIDTH-1:0] c_cnt_one      = CNT_WIDTH'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cycles;
    logic [CNT_WIDTH-1:0] w_cycles_nxt;
    logic [CNT_WIDTH-1:0] r_timeout;
    logic [CNT_WIDTH-1:0] w_timeout_nxt;
    logic [PC_WIDTH-1:0]  r_exit_addr;
    logic [PC_WIDTH-1:0]  w_exit_addr_nxt;
    logic [PC_WIDTH-1:0]  w_exit_calc;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_timed_out;

    // The sum wraps modulo 2^PC_WIDTH by construction.
    assign w_exit_calc = TEXT_START + (PC_WIDTH'(num_instr) << 2) + c_drain_offset;

    always_comb begin
        w_state_nxt     = r_state;
        w_cycles_nxt    = r_cycles;
        w_timeout_nxt   = r_timeout;
        w_exit_addr_nxt = r_exit_addr;
        if (abort) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_run: begin
                    // An X/Z pc makes the equality unknown. The if then takes
                    // its else path, so the pc is treated as a mismatch.
                    if (pc == r_exit_addr) begin
                        w_state_nxt = c_st_done;
                    end else if (r_cycles == r_timeout) begin
                        w_state_nxt = c_st_tle;
                    end else begin
                        w_cycles_nxt = r_cycles + c_cnt_one;
                    end
                end
                default: begin
                    if (start) begin
                        w_state_nxt     = c_st_run;
                        w_cycles_nxt    = '0;
                        w_timeout_nxt   = timeout;
                        w_exit_addr_nxt = w_exit_calc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= c_st_idle;
            r_cycles    <= '0;
            r_timeout   <= '0;
            r_exit_addr <= TEXT_START;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cycles    <= w_cycles_nxt;
            r_timeout   <= w_timeout_nxt;
            r_exit_addr <= w_exit_addr_nxt;
            r_busy      <= (w_state_nxt == c_st_run);
            r_done      <= (w_state_nxt == c_st_done);
            r_timed_out <= (w_state_nxt == c_st_tle);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign timed_out = r_timed_out;
    assign cycles    = r_cycles;
    assign exit_addr = r_exit_addr;

`ifdef RUN_MONITOR_STALL_CNT_EN
    logic [PC_WIDTH-1:0]  r_prev_pc;
    logic [CNT_WIDTH-1:0] r_stall_cycles;

    // Stalls are counted only on RUN cycles that remain in RUN. These are the
    // same cycles on which cycles advances, so stall_cycles never exceeds
    // cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_prev_pc      <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_prev_pc <= pc;
            if (r_state != c_st_run && w_state_nxt == c_st_run) begin
                r_stall_cycles <= '0;
            end else if (r_state == c_st_run && w_state_nxt == c_st_run &&
                         pc == r_prev_pc && r_stall_cycles != '1) begin
                r_stall_cycles <= r_stall_cycles + c_cnt_one;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_monitor
// Description : Directed self-checking bench for run_monitor. It uses the
//               default instance, plus a narrow instance with STAGES=1,
//               PC_WIDTH=16 and TEXT_START=0 to exercise the exit-address
//               wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_monitor;

    localparam logic [31:0] c_base = 32'h0040_0000;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        abort;
    logic [15:0] num_instr;
    logic [15:0] timeout;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic [15:0] cycles;
    logic [31:0] exit_addr;
    logic [15:0] stall_cycles;

    logic        start2;
    logic [15:0] num_instr2;
    logic [15:0] timeout2;
    logic [15:0] pc2;
    logic        busy2;
    logic        done2;
    logic        timed_out2;
    logic [15:0] cycles2;
    logic [15:0] exit_addr2;
    logic [15:0] stall_cycles2;

    int n_vec;
    int n_miscomp;
    logic [15:0] exp_stall_to;

    run_monitor u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .num_instr    (num_instr),
        .timeout      (timeout),
        .pc           (pc),
        .busy         (busy),
        .done         (done),
        .timed_out    (timed_out),
        .cycles       (cycles),
        .exit_addr    (exit_addr),
        .stall_cycles (stall_cycles)
    );

    run_monitor #(
        .PC_WIDTH   (16),
        .CNT_WIDTH  (16),
        .STAGES     (1),
        .TEXT_START (16'h0000)
    ) u_dut_narrow (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start2),
        .abort        (1'b0),
        .num_instr    (num_instr2),
        .timeout      (timeout2),
        .pc           (pc2),
        .busy         (busy2),
        .done         (done2),
        .timed_out    (timed_out2),
        .cycles       (cycles2),
        .exit_addr    (exit_addr2),
        .stall_cycles (stall_cycles2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscomp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse. pc_at_start is the pc value seen on the arming cycle.
    task automatic arm(input logic [15:0] n, input logic [15:0] to, input logic [31:0] pc_at_start);
        num_instr = n;
        timeout   = to;
        pc        = pc_at_start;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_miscomp = 0;
        rstn = 1'b0; start = 1'b0; abort = 1'b0;
        num_instr = '0; timeout = '0; pc = '0;
        start2 = 1'b0; num_instr2 = '0; timeout2 = '0; pc2 = '0;
`ifdef RUN_MONITOR_STALL_CNT_EN
        exp_stall_to = 16'd20;
`else
        exp_stall_to = 16'd0;
`endif
        tick();
        tick();
        check_val("rst_busy",  busy,      0);
        check_val("rst_done",  done,      0);
        check_val("rst_tle",   timed_out, 0);
        check_val("rst_cycles", cycles,   0);
        check_val("rst_exit",  exit_addr, c_base);
        check_val("rst_stall", stall_cycles, 0);
        rstn = 1'b1;
        tick();

        // Normal exit: the exit address is 0x400000 + 40 + 16 = 0x400038, reached at RUN cycle 14.
        arm(16'd10, 16'd100, c_base - 32'd4);
        check_val("norm_busy_arm", busy, 1);
        check_val("norm_exit", exit_addr, 32'h0040_0038);
        for (int k = 0; k <= 14; k++) begin
            pc = c_base + 32'(4 * k);
            tick();
            if (k == 13) check_val("norm_busy_k13", busy, 1);
        end
        check_val("norm_done",  done,      1);
        check_val("norm_busy",  busy,      0);
        check_val("norm_tle",   timed_out, 0);
        check_val("norm_cycles", cycles,   14);
        check_val("norm_stall", stall_cycles, 0);
        tick();
        tick();
        check_val("norm_hold_done", done, 1);
        check_val("norm_hold_cycles", cycles, 14);

        // Timeout: pc stuck, limit 20, so TLE occurs on the 21st RUN cycle.
        arm(16'd10, 16'd20, c_base);
        for (int k = 0; k < 20; k++) tick();
        check_val("to_busy_20", busy, 1);
        check_val("to_tle_20",  timed_out, 0);
        check_val("to_cycles_20", cycles, 20);
        tick();
        check_val("to_tle",    timed_out, 1);
        check_val("to_busy",   busy, 0);
        check_val("to_done",   done, 0);
        check_val("to_cycles", cycles, 20);
        check_val("to_stall",  stall_cycles, exp_stall_to);
        tick();
        check_val("to_hold_cycles", cycles, 20);

        // A zero limit gives TLE after a single RUN cycle.
        arm(16'd10, 16'd0, c_base);
        tick();
        check_val("to0_tle",    timed_out, 1);
        check_val("to0_cycles", cycles, 0);

        // The exit match and the limit coincide at cycle 14; the exit match wins.
        arm(16'd10, 16'd14, c_base - 32'd4);
        for (int k = 0; k <= 14; k++) begin
            pc = c_base + 32'(4 * k);
            tick();
        end
        check_val("sim_done",   done, 1);
        check_val("sim_tle",    timed_out, 0);
        check_val("sim_cycles", cycles, 14);

        // A start pulse in the middle of the run is ignored.
        arm(16'd10, 16'd100, c_base - 32'd4);
        for (int k = 0; k <= 14; k++) begin
            pc = c_base + 32'(4 * k);
            if (k == 3) begin
                start = 1'b1; num_instr = 16'd2; timeout = 16'd5;
            end
            tick();
            start = 1'b0;
            if (k == 3) check_val("ctl_exit_mid", exit_addr, 32'h0040_0038);
            if (k == 3) check_val("ctl_cycles_mid", cycles, 4);
        end
        check_val("ctl_done",   done, 1);
        check_val("ctl_cycles", cycles, 14);
        // Abort together with start returns to IDLE and keeps the latched values.
        abort = 1'b1; start = 1'b1; num_instr = 16'd2;
        tick();
        abort = 1'b0; start = 1'b0;
        check_val("abt_busy",   busy, 0);
        check_val("abt_done",   done, 0);
        check_val("abt_tle",    timed_out, 0);
        check_val("abt_cycles", cycles, 14);
        check_val("abt_exit",   exit_addr, 32'h0040_0038);
        tick();
        check_val("abt_idle_busy", busy, 0);

        // A reset in the middle of the run discards the run.
        arm(16'd10, 16'd100, c_base - 32'd4);
        for (int k = 0; k < 4; k++) begin
            pc = c_base + 32'(4 * k);
            tick();
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_val("mrst_busy",   busy, 0);
        check_val("mrst_cycles", cycles, 0);
        check_val("mrst_exit",   exit_addr, c_base);
        check_val("mrst_stall",  stall_cycles, 0);
        arm(16'd10, 16'd100, c_base - 32'd4);
        for (int k = 0; k <= 14; k++) begin
            pc = c_base + 32'(4 * k);
            tick();
        end
        check_val("mrst_rerun_done",   done, 1);
        check_val("mrst_rerun_cycles", cycles, 14);

        // Narrow instance: 0 + 4*0x4000 + 0 wraps to 0x0000.
        num_instr2 = 16'h4000; timeout2 = 16'd10; pc2 = 16'h1234; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check_val("nar_exit", exit_addr2, 16'h0000);
        check_val("nar_busy", busy2, 1);
        pc2 = 16'h0000;
        tick();
        check_val("nar_done",   done2, 1);
        check_val("nar_cycles", cycles2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of the observed program counter and exit address.
REQ-002 Parameter CNT_WIDTH, default 16, width of the cycle, timeout and instruction-count fields.
REQ-003 Parameter STAGES, default 5, pipeline depth of the observed processor, legal range 1..16.
REQ-004 Parameter TEXT_START, default 'h00400000, address of the first instruction.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 rstn  input  1  reset, synchronous and active-low.
REQ-007 start  input  1  one-cycle pulse that arms a new run.
REQ-008 abort  input  1  forces return to IDLE.
REQ-009 num_instr  input  CNT_WIDTH  instruction count of the loaded program, sampled on start.
REQ-010 timeout  input  CNT_WIDTH  cycle limit, sampled on start.
REQ-011 pc  input  PC_WIDTH  processor program counter.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  high in DONE (exit address reached).
REQ-014 timed_out  output  1  high in TLE (time limit exceeded).
REQ-015 cycles  output  CNT_WIDTH  cycles elapsed in the current or last run.
REQ-016 exit_addr  output  PC_WIDTH  latched exit address.
REQ-017 stall_cycles  output  CNT_WIDTH  RUN cycles with pc unchanged (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE, TLE; busy, done and timed_out SHALL be registered decodes of the state.
REQ-019 In IDLE, DONE or TLE, start SHALL latch exit_addr = TEXT_START + 4*num_instr + 4*(STAGES-1), truncated modulo 2^PC_WIDTH, latch timeout, clear cycles and stall_cycles, and enter RUN on the next cycle.
REQ-020 start while in RUN SHALL be ignored.
REQ-021 Each RUN cycle, pc == exit_addr SHALL transition to DONE with cycles unchanged.
REQ-022 Otherwise, cycles == latched timeout SHALL transition to TLE with cycles unchanged.
REQ-023 Otherwise, cycles SHALL increment by 1; because cycles never exceeds timeout, it SHALL never wrap.
REQ-024 When the exit match and the timeout condition occur in the same cycle, the exit match SHALL win (DONE).
REQ-025 A latched timeout of 0 SHALL give TLE after one RUN cycle unless pc already matches.
REQ-026 DONE and TLE SHALL hold, with cycles and exit_addr frozen, until start, abort or reset.
REQ-027 abort SHALL take priority over start and enter IDLE next cycle; cycles and exit_addr retain their values.
REQ-028 The pc comparison SHALL use the full PC_WIDTH bits, with X/Z on pc treated as mismatch.

Reset
REQ-029 On posedge clk with rstn low: state = IDLE, busy = done = timed_out = 0, cycles = 0, stall_cycles = 0, exit_addr = TEXT_START, latched timeout = 0, previous-pc register = 0.
REQ-030 Reset SHALL override start and abort and take effect mid-run, discarding the run.

Configuration
REQ-031 Macro RUN_MONITOR_STALL_CNT_EN defined: each RUN cycle where pc equals the previous cycle's pc SHALL increment stall_cycles, saturating at all-ones, and the previous-pc register SHALL update every cycle.
REQ-032 Macro RUN_MONITOR_STALL_CNT_EN undefined: stall_cycles SHALL be tied to 0, and no previous-pc register or stall counter SHALL be synthesised; all other behaviour SHALL be identical.

Verification
REQ-033 Normal exit: num_instr=10, timeout=100, pc advancing 'h00400000 +4 per cycle -> exit_addr='h00400038, done=1, busy=0, cycles=14.
REQ-034 Timeout: num_instr=10, timeout=20, pc stuck at 'h00400000 -> timed_out=1 after 21 RUN cycles, cycles=20; stall_cycles=20 with the macro, 0 without.
REQ-035 Simultaneous event: pc reaches exit_addr in the cycle where cycles==timeout -> done=1, timed_out=0.
REQ-036 Controls: start pulsed mid-RUN -> ignored, exit_addr and cycles unaffected; abort and start asserted together -> IDLE.
REQ-037 Reset mid-RUN: rstn low for 1 cycle -> all outputs at reset values next cycle; a following start runs normally.
REQ-038 Parameterisation: STAGES=1, PC_WIDTH=16, TEXT_START=0, num_instr='h4000 -> exit_addr wraps to 'h0000.
